// File: rtl/hilo_unit.sv
// HI/LO result register unit: captures multi-cycle multiplier/divider results with a wait timeout.
// Optional feature: define HILO_ACC_EN to let a multiplier capture accumulate into {HI,LO}.
module hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             src_sel,
    input  logic             acc,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             mult_done,
    input  logic [WIDTH-1:0] div_hi,
    input  logic [WIDTH-1:0] div_lo,
    input  logic             div_done,
    input  logic             div_zero,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             dz_exc,
    output logic             timeout_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MULT = 2'd1,
        WAIT_DIV  = 2'd2
    } state_t;

    // The wait counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              acc_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              dz_q;
    logic              to_q;
    logic [WIDTH-1:0]  mult_hi_d;
    logic [WIDTH-1:0]  mult_lo_d;

`ifdef HILO_ACC_EN
    logic [2*WIDTH-1:0] acc_sum_d;

    // Carry out of the double-width sum is intentionally dropped.
    assign acc_sum_d = {hi_q, lo_q} + {mult_hi, mult_lo};

    always_comb begin
        mult_hi_d = mult_hi;
        mult_lo_d = mult_lo;
        if (acc_q) begin
            mult_hi_d = acc_sum_d[2*WIDTH-1:WIDTH];
            mult_lo_d = acc_sum_d[WIDTH-1:0];
        end
    end
`else
    logic unused_acc;

    assign mult_hi_d  = mult_hi;
    assign mult_lo_d  = mult_lo;
    assign unused_acc = acc_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            dz_q <= 1'b0;
            to_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mthi) hi_q <= wr_data;
                    if (mtlo) lo_q <= wr_data;
                    if (start) begin
                        state_q <= src_sel ? WAIT_DIV : WAIT_MULT;
                        acc_q   <= acc;
                        cnt_q   <= '0;
                    end
                end
                WAIT_MULT: begin
                    if (mult_done) begin
                        hi_q    <= mult_hi_d;
                        lo_q    <= mult_lo_d;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DIV: begin
                    // A done always wins over a timeout landing in the same cycle.
                    if (div_done) begin
                        if (div_zero) begin
                            dz_q <= 1'b1;
                        end else begin
                            hi_q <= div_hi;
                            lo_q <= div_lo;
                        end
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        to_q    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign busy        = (state_q != IDLE);
    assign dz_exc      = dz_q;
    assign timeout_err = to_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit: a cycle-by-cycle vector table plus timeout sequences.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset, start, src_sel, acc;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo, wr_data;
    logic        mult_done, div_done, div_zero, mthi, mtlo;
    logic [31:0] hi_out, lo_out;
    logic        busy, dz_exc, timeout_err;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    hilo_unit #(.WIDTH(32), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .src_sel(src_sel), .acc(acc),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_done(mult_done),
        .div_hi(div_hi), .div_lo(div_lo), .div_done(div_done), .div_zero(div_zero),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .dz_exc(dz_exc),
        .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, sel, ac, md, dd, dz, wh, wl;
        logic [31:0] dhi, dlo, wd;
        logic [31:0] e_hi, e_lo;
        logic        e_busy, e_dz, e_to;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, st, sel, ac, md, dd, dz, wh, wl,
                       input logic [31:0] dhi, dlo, wd, e_hi, e_lo,
                       input logic e_busy, e_dz, e_to);
        vec_t v;
        v.rst = rst; v.st = st; v.sel = sel; v.ac = ac; v.md = md; v.dd = dd;
        v.dz = dz; v.wh = wh; v.wl = wl; v.dhi = dhi; v.dlo = dlo; v.wd = wd;
        v.e_hi = e_hi; v.e_lo = e_lo; v.e_busy = e_busy; v.e_dz = e_dz; v.e_to = e_to;
        vecs.push_back(v);
    endtask

    task automatic clear_inputs();
        reset = 0; start = 0; src_sel = 0; acc = 0;
        mult_hi = 0; mult_lo = 0; mult_done = 0;
        div_hi = 0; div_lo = 0; div_done = 0; div_zero = 0;
        mthi = 0; mtlo = 0; wr_data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_hi, e_lo,
                           input logic e_busy, e_dz, e_to);
        chk({tag, " hi"}, hi_out, e_hi);
        chk({tag, " lo"}, lo_out, e_lo);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, e_busy});
        chk({tag, " dz_exc"}, {31'd0, dz_exc}, {31'd0, e_dz});
        chk({tag, " timeout_err"}, {31'd0, timeout_err}, {31'd0, e_to});
    endtask

    initial begin
        logic [31:0] acc_hi, acc_lo;
`ifdef HILO_ACC_EN
        acc_hi = 32'h1; acc_lo = 32'h0;
`else
        acc_hi = 32'h0; acc_lo = 32'h1;
`endif
        clear_inputs();
        //   rst st sel ac md dd dz wh wl  dhi           dlo           wd            e_hi          e_lo          bsy dz to
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h12345678, 32'h0,        32'h12345678, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 0, 0, 32'hAAAA,     32'hBBBB,     32'h0,        32'hCAFEF00D, 32'h12345678, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h7777,     32'h8888,     32'h0,        32'hCAFEF00D, 32'h12345678, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hCAFEF00D, 32'h12345678, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h1,        32'hFFFFFFFF, 32'h0,        32'h1,        32'hFFFFFFFF, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0,        32'h55,       32'h55,       32'h55,       1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h1234,     32'h5678,     32'h99,       32'h55,       32'h55,       1, 0, 0);
        add(0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h77,       32'h88,       32'h0,        32'h55,       32'h55,       0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h55,       32'h55,       0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h55,       32'h55,       1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 32'hDEAD0001, 32'hBEEF0002, 32'h0,        32'hDEAD0001, 32'hBEEF0002, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hDEAD0001, 32'hFFFFFFFF, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h1,        32'h0,        acc_hi,       acc_lo,       0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        acc_hi,       acc_lo,       1, 0, 0);
        add(1, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0);

        foreach (vecs[i]) begin
            reset = vecs[i].rst; start = vecs[i].st; src_sel = vecs[i].sel; acc = vecs[i].ac;
            mult_done = vecs[i].md; mult_hi = vecs[i].dhi; mult_lo = vecs[i].dlo;
            div_done = vecs[i].dd; div_zero = vecs[i].dz; div_hi = vecs[i].dhi; div_lo = vecs[i].dlo;
            mthi = vecs[i].wh; mtlo = vecs[i].wl; wr_data = vecs[i].wd;
            tick();
            chk_all($sformatf("row%0d", i), vecs[i].e_hi, vecs[i].e_lo,
                    vecs[i].e_busy, vecs[i].e_dz, vecs[i].e_to);
        end
        clear_inputs();
        chk("idle state", {30'd0, state_dbg}, 32'd0);

        // Timeout with no done; a direct write while busy must be dropped.
        mthi = 1; wr_data = 32'h13579BDF;
        tick(); clear_inputs();
        chk("to preload hi", hi_out, 32'h13579BDF);
        start = 1; src_sel = 0;
        tick(); clear_inputs();
        chk("to busy after start", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 64; i++) begin
            if (i == 10) begin mthi = 1; wr_data = 32'h0000FFFF; end
            tick(); clear_inputs();
            chk($sformatf("to wait%0d busy", i), {31'd0, busy}, 32'd1);
            chk($sformatf("to wait%0d err", i), {31'd0, timeout_err}, 32'd0);
        end
        tick();
        chk_all("to fire", 32'h13579BDF, 32'h0, 0, 0, 1);
        tick();
        chk_all("to after", 32'h13579BDF, 32'h0, 0, 0, 0);

        // A done in the last wait cycle wins over the timeout.
        start = 1; src_sel = 1;
        tick(); clear_inputs();
        for (int i = 1; i < 64; i++) tick();
        chk("prio still busy", {31'd0, busy}, 32'd1);
        div_done = 1; div_hi = 32'h11112222; div_lo = 32'h33334444;
        tick(); clear_inputs();
        chk_all("prio done", 32'h11112222, 32'h33334444, 0, 0, 0);
        tick();
        chk_all("prio after", 32'h11112222, 32'h33334444, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the data width of the HI and LO registers and all data ports.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of wait cycles for a done pulse.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to capture a multi-cycle result.
REQ-006 src_sel  input  1  source select: 0 = multiplier, 1 = divider.
REQ-007 acc  input  1  accumulate request, qualified with start and src_sel=0.
REQ-008 mult_hi, mult_lo  input  WIDTH each  multiplier result halves.
REQ-009 mult_done  input  1  multiplier result-valid pulse.
REQ-010 div_hi, div_lo  input  WIDTH each  divider remainder and quotient.
REQ-011 div_done  input  1  divider result-valid pulse.
REQ-012 div_zero  input  1  divide-by-zero flag, qualified by div_done.
REQ-013 mthi, mtlo  input  1 each  direct-write strobes for HI and LO.
REQ-014 wr_data  input  WIDTH  direct-write data.
REQ-015 hi_out, lo_out  output  WIDTH each  registered HI and LO contents.
REQ-016 busy  output  1  high while a capture is pending.
REQ-017 dz_exc  output  1  one-cycle divide-by-zero pulse.
REQ-018 timeout_err  output  1  one-cycle timeout pulse.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, WAIT_MULT and WAIT_DIV.
REQ-020 In IDLE, start=1 SHALL move the FSM to WAIT_MULT (src_sel=0) or WAIT_DIV (src_sel=1), latch acc, clear the wait counter, and drive busy=1 from the next cycle.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 done inputs SHALL be sampled only in the matching WAIT state; a done in the same cycle as start, or from the non-selected unit, SHALL be ignored.
REQ-023 In WAIT_MULT, mult_done=1 SHALL load HI<=mult_hi and LO<=mult_lo at that edge and return the FSM to IDLE, so hi_out/lo_out update one cycle after done.
REQ-024 In WAIT_DIV, div_done=1 with div_zero=0 SHALL load HI<=div_hi and LO<=div_lo and return the FSM to IDLE.
REQ-025 div_done=1 with div_zero=1 SHALL leave HI/LO unchanged, pulse dz_exc for one cycle, and return the FSM to IDLE.
REQ-026 The wait counter SHALL increment each cycle spent in a WAIT state.
REQ-027 When the wait counter reaches TIMEOUT-1 without a done, the FSM SHALL return to IDLE, pulse timeout_err for one cycle, and leave HI/LO unchanged.
REQ-028 A done arriving in the timeout cycle SHALL take priority over the timeout, which SHALL then not fire.
REQ-029 mthi/mtlo SHALL write wr_data to HI/LO only when the FSM is in IDLE; they SHALL be ignored while busy.
REQ-030 mthi and mtlo asserted in the same cycle SHALL both write wr_data.
REQ-031 When mthi/mtlo and start are asserted in the same IDLE cycle, both SHALL take effect.
REQ-032 busy SHALL equal 1 exactly when the FSM is in WAIT_MULT or WAIT_DIV.

Reset
REQ-033 reset=1 SHALL force the FSM to IDLE and clear hi_out, lo_out, busy, dz_exc, timeout_err, the wait counter and the latched acc on the next edge.
REQ-034 reset SHALL take priority over all other inputs, including mid-wait; a done in the reset cycle SHALL be discarded.

Configuration
REQ-035 With macro HILO_ACC_EN defined, a multiplier capture with latched acc=1 SHALL load {HI,LO} <= {HI,LO} + {mult_hi,mult_lo}, a 2*WIDTH-bit unsigned sum with the carry-out discarded.
REQ-036 Without HILO_ACC_EN, the acc port SHALL remain present but be ignored, and every capture SHALL be a plain load.

Verification
REQ-037 reset; mtlo=1, wr_data=0x12345678 in IDLE -> lo_out=0x12345678 next cycle, hi_out=0.
REQ-038 start, src_sel=0; mult_done with mult_hi=0x1, mult_lo=0xFFFFFFFF 3 cycles later -> busy high for 3 cycles, then hi_out=0x1 and lo_out=0xFFFFFFFF.
REQ-039 start, src_sel=1; div_done with div_zero=1 -> dz_exc=1 for one cycle, HI/LO unchanged, busy=0.
REQ-040 start, no done for 64 cycles -> timeout_err pulses once, busy drops, HI/LO unchanged; mthi while busy -> ignored.
REQ-041 With HILO_ACC_EN: HI=0, LO=0xFFFFFFFF; acc mult capture of {0,1} -> HI=0x1, LO=0.
REQ-042 reset asserted in WAIT_DIV concurrently with div_done -> FSM=IDLE, outputs 0, no dz_exc pulse.
